// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared traffic light types, monitor states and fault codes
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        LEFT   = 2'd1,
        GREEN  = 2'd2,
        YELLOW = 2'd3
    } traffic_light;

    typedef enum logic [2:0] {
        FC_NONE          = 3'd0,
        FC_CONFLICT      = 3'd1,
        FC_ILLEGAL_TRANS = 3'd2,
        FC_SHORT_YELLOW  = 3'd3,
        FC_STALL         = 3'd4
    } fault_code_t;

    typedef enum logic [1:0] {
        ARMING = 2'd0,
        RUN    = 2'd1,
        FAULT  = 2'd2
    } mon_state_t;

    // Holding a colour is always legal; otherwise only the forward colour cycle is allowed.
    function automatic logic legal_transition(traffic_light prev, traffic_light cur);
        logic ok;
        ok = 1'b0;
        if (prev == cur) begin
            ok = 1'b1;
        end else begin
            case (prev)
                RED:     ok = (cur == LEFT) || (cur == GREEN);
                LEFT:    ok = (cur == GREEN);
                GREEN:   ok = (cur == YELLOW);
                YELLOW:  ok = (cur == RED);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/light_safety_monitor_if.sv
// rtl/light_safety_monitor_if.sv - controller-side and lamp-side signals of the safety monitor
interface light_safety_monitor_if
    import traffic_pkg::*;
#(
    parameter int CNT_W = 8
);
    traffic_light     north_in;
    traffic_light     south_in;
    traffic_light     east_in;
    traffic_light     west_in;
    logic             fault_clr;
    traffic_light     north_out;
    traffic_light     south_out;
    traffic_light     east_out;
    traffic_light     west_out;
    logic             fault;
    logic [2:0]       fault_code;
    logic [CNT_W-1:0] fault_cnt;

    modport master (
        output north_in, south_in, east_in, west_in, fault_clr,
        input  north_out, south_out, east_out, west_out, fault, fault_code, fault_cnt
    );

    modport slave (
        input  north_in, south_in, east_in, west_in, fault_clr,
        output north_out, south_out, east_out, west_out, fault, fault_code, fault_cnt
    );
endinterface

// File: rtl/light_dir_check.sv
// rtl/light_dir_check.sv - per-direction transition legality and minimum yellow time check
module light_dir_check
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  traffic_light cur,
    input  traffic_light prev,
    output logic         illegal_trans,
    output logic         short_yellow
);
    localparam int YW = $clog2(MIN_YELLOW + 1);
    localparam logic [YW-1:0] YEL_MAX = YW'(MIN_YELLOW);

    // Holds the yellow run length including the previous sample when compared below.
    logic [YW-1:0] yel_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yel_cnt <= '0;
        end else if (!run || cur != YELLOW) begin
            yel_cnt <= '0;
        end else if (yel_cnt != YEL_MAX) begin
            yel_cnt <= yel_cnt + 1'b1;
        end
    end

    assign illegal_trans = run && !legal_transition(prev, cur);
    assign short_yellow  = run && (prev == YELLOW) && (cur == RED) && (yel_cnt < YEL_MAX);

endmodule

// File: rtl/light_safety_monitor.sv
// rtl/light_safety_monitor.sv - checks light_fsm outputs and forces all lamps RED on a latched fault
module light_safety_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 3,
    parameter int MAX_STILL  = 64,
    parameter int CNT_W      = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    light_safety_monitor_if.slave mon
);
    localparam int SW = $clog2(MAX_STILL + 1);
    localparam logic [SW-1:0] STILL_MAX = SW'(MAX_STILL);
    localparam logic [SW-1:0] STILL_TRIP = SW'(MAX_STILL - 1);

    mon_state_t       state, state_next;
    traffic_light     cur [4];
    traffic_light     prev [4];
    traffic_light     lamp_q [4];
    traffic_light     lamp_d [4];
    logic             fault_q, fault_d;
    fault_code_t      code_q, code_d, viol_code;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    still_cnt;
    logic [3:0]       illegal_v, short_v;
    logic             run, conflict, unchanged, stall;

    assign run = (state == RUN);

    always_comb begin
        cur[0] = mon.north_in;
        cur[1] = mon.south_in;
        cur[2] = mon.east_in;
        cur[3] = mon.west_in;
    end

    for (genvar d = 0; d < 4; d++) begin : g_dir
        light_dir_check #(.MIN_YELLOW(MIN_YELLOW)) u_dir (
            .clk           (clk),
            .rst_n         (rst_n),
            .run           (run),
            .cur           (cur[d]),
            .prev          (prev[d]),
            .illegal_trans (illegal_v[d]),
            .short_yellow  (short_v[d])
        );
    end

    assign conflict  = ((cur[0] != RED) || (cur[1] != RED)) &&
                       ((cur[2] != RED) || (cur[3] != RED));
    assign unchanged = (cur[0] == prev[0]) && (cur[1] == prev[1]) &&
                       (cur[2] == prev[2]) && (cur[3] == prev[3]);
    // Trips on the sample that would make the unchanged run MAX_STILL long.
    assign stall     = run && unchanged && (still_cnt == STILL_TRIP);

    always_comb begin
        viol_code = FC_NONE;
        if (conflict)        viol_code = FC_CONFLICT;
        else if (|illegal_v) viol_code = FC_ILLEGAL_TRANS;
        else if (|short_v)   viol_code = FC_SHORT_YELLOW;
        else if (stall)      viol_code = FC_STALL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            still_cnt <= '0;
            for (int d = 0; d < 4; d++) prev[d] <= RED;
        end else begin
            for (int d = 0; d < 4; d++) prev[d] <= cur[d];
            if (!run || !unchanged) begin
                still_cnt <= '0;
            end else if (still_cnt != STILL_MAX) begin
                still_cnt <= still_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARMING;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARMING:  if (unchanged && (cur[0] == RED) && (cur[1] == RED) &&
                         (cur[2] == RED) && (cur[3] == RED)) state_next = RUN;
                     else if ((cur[0] == RED) && (cur[1] == RED) &&
                         (cur[2] == RED) && (cur[3] == RED)) state_next = RUN;
            RUN:     if (viol_code != FC_NONE) state_next = FAULT;
            FAULT:   if (mon.fault_clr) state_next = ARMING;
            default: state_next = ARMING;
        endcase
    end

    // Lamps follow the inputs only when the sample just taken keeps us in RUN.
    always_comb begin
        for (int d = 0; d < 4; d++) lamp_d[d] = (state_next == RUN) ? cur[d] : RED;
        fault_d = (state_next == FAULT);
        code_d  = code_q;
        cnt_d   = cnt_q;
        if (run && viol_code != FC_NONE) begin
            code_d = viol_code;
            cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end else if (state == FAULT && mon.fault_clr) begin
            code_d = FC_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 4; d++) lamp_q[d] <= RED;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
            cnt_q   <= '0;
        end else begin
            for (int d = 0; d < 4; d++) lamp_q[d] <= lamp_d[d];
            fault_q <= fault_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mon.north_out  = lamp_q[0];
    assign mon.south_out  = lamp_q[1];
    assign mon.east_out   = lamp_q[2];
    assign mon.west_out   = lamp_q[3];
    assign mon.fault      = fault_q;
    assign mon.fault_code = code_q;
    assign mon.fault_cnt  = cnt_q;

endmodule

// File: tb/tb_light_safety_monitor.sv
// tb/tb_light_safety_monitor.sv - scoreboard bench for light_safety_monitor
module tb_light_safety_monitor;
    import traffic_pkg::*;

    localparam int MIN_Y = 3;
    localparam int MAX_S = 8;

    typedef struct packed {
        logic [7:0] lamps;
        logic       fault;
        logic [2:0] code;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    exp_t         sb_q[$];
    int           m_state;
    traffic_light m_cur [4];
    traffic_light m_prev [4];
    int           m_yel [4];
    int           m_still, m_code, m_cnt;

    light_safety_monitor_if #(.CNT_W(8)) bus ();

    light_safety_monitor #(.MIN_YELLOW(MIN_Y), .MAX_STILL(MAX_S), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit tb_legal(traffic_light p, traffic_light c);
        logic [15:0] tbl;
        tbl = 16'h9C67;
        return tbl[{p, c}];
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_still = 0;
        m_code  = 0;
        m_cnt   = 0;
        for (int d = 0; d < 4; d++) begin
            m_prev[d] = RED;
            m_yel[d]  = 0;
        end
    endtask

    task automatic model_step(input logic clr);
        bit   all_red, same, conf, ill, shrt, stl;
        int   code;
        exp_t ex;
        all_red = 1;
        same    = 1;
        for (int d = 0; d < 4; d++) begin
            if (m_cur[d] != RED) all_red = 0;
            if (m_cur[d] != m_prev[d]) same = 0;
        end
        if (m_state == 0) begin
            if (all_red) m_state = 1;
        end else if (m_state == 1) begin
            conf = (m_cur[0] != RED || m_cur[1] != RED) && (m_cur[2] != RED || m_cur[3] != RED);
            ill  = 0;
            shrt = 0;
            for (int d = 0; d < 4; d++) begin
                if (!tb_legal(m_prev[d], m_cur[d])) ill = 1;
                if (m_prev[d] == YELLOW && m_cur[d] == RED && m_yel[d] < MIN_Y) shrt = 1;
                m_yel[d] = (m_cur[d] == YELLOW) ? ((m_yel[d] < MIN_Y) ? m_yel[d] + 1 : MIN_Y) : 0;
            end
            m_still = same ? m_still + 1 : 0;
            stl  = (m_still == MAX_S);
            code = 0;
            if (stl)  code = 4;
            if (shrt) code = 3;
            if (ill)  code = 2;
            if (conf) code = 1;
            if (code != 0) begin
                m_state = 2;
                m_code  = code;
                if (m_cnt < 255) m_cnt++;
            end
        end else begin
            if (clr) begin
                m_state = 0;
                m_code  = 0;
            end
        end
        if (m_state != 1) begin
            m_still = 0;
            for (int d = 0; d < 4; d++) m_yel[d] = 0;
        end
        for (int d = 0; d < 4; d++) m_prev[d] = m_cur[d];
        if (m_state == 1) ex.lamps = {m_cur[0], m_cur[1], m_cur[2], m_cur[3]};
        else              ex.lamps = 8'h00;
        ex.fault = (m_state == 2);
        ex.code  = 3'(m_code);
        ex.cnt   = 8'(m_cnt);
        sb_q.push_back(ex);
    endtask

    task automatic drive(input traffic_light n, input traffic_light s, input traffic_light e,
                         input traffic_light w, input logic clr);
        exp_t ex;
        @(negedge clk);
        bus.north_in  = n;
        bus.south_in  = s;
        bus.east_in   = e;
        bus.west_in   = w;
        bus.fault_clr = clr;
        m_cur[0] = n;
        m_cur[1] = s;
        m_cur[2] = e;
        m_cur[3] = w;
        model_step(clr);
        @(posedge clk);
        #1;
        ex = sb_q.pop_front();
        check("lamps", {bus.north_out, bus.south_out, bus.east_out, bus.west_out}, ex.lamps);
        check("fault", bus.fault, ex.fault);
        check("fault_code", bus.fault_code, ex.code);
        check("fault_cnt", bus.fault_cnt, ex.cnt);
    endtask

    task automatic drive_ns(input traffic_light c, input int cycles);
        for (int i = 0; i < cycles; i++) drive(c, c, RED, RED, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_lamps"}, {bus.north_out, bus.south_out, bus.east_out, bus.west_out}, 8'h00);
        check({tag, "_fault"}, bus.fault, 1'b0);
        check({tag, "_code"}, bus.fault_code, 3'd0);
        check({tag, "_cnt"}, bus.fault_cnt, 8'd0);
    endtask

    task automatic clear_to_run();
        drive(RED, RED, RED, RED, 1'b1);
        drive(RED, RED, RED, RED, 1'b0);
    endtask

    initial begin
        bus.north_in  = RED;
        bus.south_in  = RED;
        bus.east_in   = RED;
        bus.west_in   = RED;
        bus.fault_clr = 1'b0;
        model_reset();
        #3;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        drive_ns(RED, 2);
        drive_ns(LEFT, 2);
        drive_ns(GREEN, 5);
        drive_ns(YELLOW, 3);
        drive_ns(RED, 2);

        drive(GREEN, RED, GREEN, RED, 1'b0);
        drive(GREEN, RED, GREEN, RED, 1'b0);
        drive(GREEN, RED, GREEN, RED, 1'b0);
        clear_to_run();

        drive(RED, GREEN, RED, RED, 1'b0);
        drive(RED, GREEN, RED, RED, 1'b0);
        drive(RED, YELLOW, RED, RED, 1'b0);
        drive(RED, YELLOW, RED, RED, 1'b0);
        drive(RED, RED, RED, RED, 1'b0);
        clear_to_run();

        drive(GREEN, RED, RED, RED, 1'b0);
        drive(GREEN, RED, RED, RED, 1'b0);
        drive(RED, RED, RED, RED, 1'b0);
        clear_to_run();

        drive_ns(GREEN, 1);
        drive(RED, GREEN, GREEN, GREEN, 1'b0);
        clear_to_run();

        drive_ns(GREEN, MAX_S + 1);
        drive(GREEN, GREEN, RED, RED, 1'b1);
        drive_ns(GREEN, 2);
        drive_ns(RED, 2);
        drive_ns(LEFT, 2);

        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_state("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        drive_ns(RED, 2);

        for (int i = 0; i < 80; i++) begin
            drive(traffic_light'($urandom_range(3)), traffic_light'($urandom_range(3)),
                  (i % 3 == 0) ? traffic_light'($urandom_range(3)) : RED, RED,
                  ($urandom_range(3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
